nds_fifo_rd_ctrl: RTL and testbench

NDS_FIFO_RD_CTRL -- requirements
Module: nds_fifo_rd_ctrl

---
 rtl/nds_fifo_rd_ctrl.sv | 137 +++++++++++++
 tb/tb_nds_fifo_rd_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nds_fifo_rd_ctrl.sv
// Read-side controller for a show-ahead FIFO. Moves tran_cnt words from the
// FIFO head into a single-entry valid/ready output register. The output
// register can be refilled in the same cycle that it is accepted.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start; remain_cnt keeps its last value
// XFER   | popping FIFO words and presenting them to the destination
// DONE   | one cycle at the end of a normal transfer; done is high
module nds_fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  tran_cnt,
  input  logic                  abort,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd,
  output logic                  dst_valid,
  output logic [DATA_WIDTH-1:0] dst_data,
  input  logic                  dst_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [CNT_WIDTH-1:0]  remain_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_WIDTH-1:0]  r_pop_cnt;
  logic [CNT_WIDTH-1:0]  r_remain_cnt;
  logic [DATA_WIDTH-1:0] r_dst_data;
  logic                  r_dst_valid;
  logic                  r_aborted;
  logic                  w_fifo_rd;
  logic                  w_accept;
  logic                  w_load;
  logic                  w_abort_xfer;

  assign w_accept = r_dst_valid && dst_ready;
  assign w_load   = (r_state == S_IDLE) && start;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state, pop strobe and abort decode. An abort that lands on the
  // acceptance of the last word loses to the normal completion.
  always_comb begin
    w_next_state = r_state;
    w_fifo_rd    = 1'b0;
    w_abort_xfer = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = (tran_cnt != '0) ? S_XFER : S_DONE;
        end
      end
      S_XFER: begin
        w_fifo_rd = (r_pop_cnt != '0) && !fifo_empty && !abort &&
                    (!r_dst_valid || dst_ready);
        if (w_accept && (r_remain_cnt == CNT_ONE)) begin
          w_next_state = S_DONE;
        end else if (abort) begin
          w_next_state = S_IDLE;
          w_abort_xfer = 1'b1;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Counters, output word register and abort pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pop_cnt    <= '0;
      r_remain_cnt <= '0;
      r_dst_data   <= '0;
      r_dst_valid  <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_aborted <= w_abort_xfer;
      if (w_load) begin
        r_pop_cnt    <= tran_cnt;
        r_remain_cnt <= tran_cnt;
      end else begin
        if (w_fifo_rd && (r_pop_cnt != '0)) begin
          r_pop_cnt <= r_pop_cnt - CNT_ONE;
        end
        if (w_accept && (r_remain_cnt != '0)) begin
          r_remain_cnt <= r_remain_cnt - CNT_ONE;
        end
      end
      if (w_fifo_rd) begin
        r_dst_data <= fifo_rd_data;
      end
      // An aborted word is dropped, not delivered.
      if (w_abort_xfer) begin
        r_dst_valid <= 1'b0;
      end else if (w_fifo_rd) begin
        r_dst_valid <= 1'b1;
      end else if (w_accept) begin
        r_dst_valid <= 1'b0;
      end
    end
  end

  assign fifo_rd    = w_fifo_rd;
  assign dst_valid  = r_dst_valid;
  assign dst_data   = r_dst_data;
  assign busy       = (r_state == S_XFER) || (r_state == S_DONE);
  assign done       = (r_state == S_DONE);
  assign aborted    = r_aborted;
  assign remain_cnt = r_remain_cnt;

endmodule

// File: tb/tb_nds_fifo_rd_ctrl.sv
// Directed bench for nds_fifo_rd_ctrl with a small show-ahead FIFO model.
module tb_nds_fifo_rd_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] tran_cnt;
  logic        abort;
  logic        fifo_empty;
  logic [31:0] fifo_rd_data;
  logic        fifo_rd;
  logic        dst_valid;
  logic [31:0] dst_data;
  logic        dst_ready;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] remain_cnt;

  logic [31:0] q[$];
  logic [31:0] got[$];
  int          n_pop;
  int          n_done;
  int          n_abt;
  bit          pop_pend;
  bit          hold_empty;
  int          n_total = 0;
  int          n_bad   = 0;

  nds_fifo_rd_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .tran_cnt     (tran_cnt),
    .abort        (abort),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd      (fifo_rd),
    .dst_valid    (dst_valid),
    .dst_data     (dst_data),
    .dst_ready    (dst_ready),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .remain_cnt   (remain_cnt)
  );

  always #5 clk = ~clk;

  // Mid-cycle observer: pop/done/abort counts and accepted words
  always @(negedge clk) begin
    pop_pend = fifo_rd;
    if (fifo_rd) n_pop++;
    if (done) n_done++;
    if (aborted) n_abt++;
    if (dst_valid && dst_ready) got.push_back(dst_data);
  end

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic upd();
    fifo_empty   = (q.size() == 0) || hold_empty;
    fifo_rd_data = (q.size() != 0) ? q[0] : 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (pop_pend) begin
      if (q.size() != 0) void'(q.pop_front());
      pop_pend = 1'b0;
    end
    upd();
  endtask

  task automatic clr();
    n_pop = 0; n_done = 0; n_abt = 0;
    got.delete(); q.delete();
    hold_empty = 1'b0; pop_pend = 1'b0;
    upd();
  endtask

  task automatic run_to_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (n_done > 0) break;
    end
    check_val("done_seen", n_done, 1);
  endtask

  task automatic check_words(input string tag, input logic [31:0] base, input int n);
    check_val({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++)
      check_val({tag, "_word"}, got[i], base + i);
  endtask

  initial begin
    bit   e_rd[7]    = '{1, 1, 1, 1, 0, 0, 0};
    bit   e_val[7]   = '{0, 1, 1, 1, 1, 0, 0};
    int   e_rem[7]   = '{4, 4, 3, 2, 1, 0, 0};
    bit   e_done[7]  = '{0, 0, 0, 0, 0, 1, 0};
    bit   e_busy[7]  = '{1, 1, 1, 1, 1, 1, 0};

    reset_n = 1'b0; start = 1'b0; tran_cnt = '0; abort = 1'b0; dst_ready = 1'b0;
    clr();
    q.push_back(32'h1234_5678); upd();
    step(); step();
    check_val("rst_fifo_rd", fifo_rd, 0);
    check_val("rst_valid", dst_valid, 0);
    check_val("rst_data", dst_data, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_aborted", aborted, 0);
    check_val("rst_remain", remain_cnt, 0);
    reset_n = 1'b1;
    step();

    // 4 words, destination always ready
    clr();
    for (int i = 0; i < 4; i++) q.push_back(32'hA000_0000 + i);
    upd();
    dst_ready = 1'b1; start = 1'b1; tran_cnt = 16'd4;
    #1;
    check_val("t1_c0_rd", fifo_rd, 0);
    step();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      #1;
      check_val("t1_rd", fifo_rd, e_rd[c-1]);
      check_val("t1_valid", dst_valid, e_val[c-1]);
      if (e_val[c-1]) check_val("t1_data", dst_data, 32'hA000_0000 + c - 2);
      check_val("t1_remain", remain_cnt, e_rem[c-1]);
      check_val("t1_done", done, e_done[c-1]);
      check_val("t1_busy", busy, e_busy[c-1]);
      step();
    end
    check_val("t1_pops", n_pop, 4);

    // 3 words, destination ready alternates; extra FIFO word must stay
    clr();
    for (int i = 0; i < 4; i++) q.push_back(32'hB000_0000 + i);
    upd();
    start = 1'b1; tran_cnt = 16'd3; dst_ready = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      dst_ready = c[0];
      #1;
      if (dst_valid) check_val("t2_data", dst_data, 32'hB000_0000 + got.size());
      step();
      if (n_done > 0) break;
    end
    check_val("t2_done", n_done, 1);
    check_val("t2_pops", n_pop, 3);
    check_val("t2_left", q.size(), 1);
    check_words("t2", 32'hB000_0000, 3);

    // 5 words, FIFO empty cycles 3-5; stray start in XFER ignored
    clr();
    for (int i = 0; i < 5; i++) q.push_back(32'hC000_0000 + i);
    upd();
    start = 1'b1; tran_cnt = 16'd5; dst_ready = 1'b1;
    step();
    for (int c = 1; c <= 40; c++) begin
      hold_empty = (c >= 3 && c <= 5);
      start = (c == 2);
      tran_cnt = (c == 2) ? 16'd9 : 16'd5;
      upd();
      #1;
      if (hold_empty) begin
        check_val("t3_stall_rd", fifo_rd, 0);
        check_val("t3_stall_busy", busy, 1);
      end
      if (c == 6) check_val("t3_resume_rd", fifo_rd, 1);
      step();
      if (n_done > 0) break;
    end
    start = 1'b0;
    check_val("t3_done", n_done, 1);
    check_val("t3_pops", n_pop, 5);
    check_val("t3_remain", remain_cnt, 0);
    check_words("t3", 32'hC000_0000, 5);

    // Zero-length transfer; abort in DONE ignored
    clr();
    q.push_back(32'hD00D_0000); upd();
    start = 1'b1; tran_cnt = 16'd0;
    step();
    start = 1'b0; abort = 1'b1;
    #1;
    check_val("t4_done", done, 1);
    check_val("t4_busy", busy, 1);
    check_val("t4_rd", fifo_rd, 0);
    step();
    abort = 1'b0;
    #1;
    check_val("t4_done_end", done, 0);
    check_val("t4_busy_end", busy, 0);
    check_val("t4_aborted", aborted, 0);
    check_val("t4_pops", n_pop, 0);

    // 8 words, abort after 3 acceptances with word 4 pending
    clr();
    for (int i = 0; i < 8; i++) q.push_back(32'hE000_0000 + i);
    upd();
    start = 1'b1; tran_cnt = 16'd8; dst_ready = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) step();
    dst_ready = 1'b0; abort = 1'b1;
    #1;
    check_val("t5_abort_rd", fifo_rd, 0);
    check_val("t5_abort_valid", dst_valid, 1);
    check_val("t5_abort_data", dst_data, 32'hE000_0003);
    step();
    abort = 1'b0;
    #1;
    check_val("t5_valid", dst_valid, 0);
    check_val("t5_aborted", aborted, 1);
    check_val("t5_busy", busy, 0);
    check_val("t5_remain", remain_cnt, 5);
    step();
    #1;
    check_val("t5_aborted_pulse", aborted, 0);
    check_val("t5_remain_hold", remain_cnt, 5);
    check_val("t5_pops", n_pop, 4);
    check_val("t5_done", n_done, 0);
    check_val("t5_accepts", got.size(), 3);

    // Abort on the first XFER cycle suppresses the pop that would happen
    clr();
    for (int i = 0; i < 2; i++) q.push_back(32'hE100_0000 + i);
    upd();
    start = 1'b1; tran_cnt = 16'd2; dst_ready = 1'b1;
    step();
    start = 1'b0; abort = 1'b1;
    #1;
    check_val("t5b_rd", fifo_rd, 0);
    step();
    abort = 1'b0;
    #1;
    check_val("t5b_aborted", aborted, 1);
    check_val("t5b_remain", remain_cnt, 2);
    check_val("t5b_pops", n_pop, 0);

    // Reset mid-transfer, then a clean 2-word transfer
    step();
    clr();
    for (int i = 0; i < 4; i++) q.push_back(32'hF000_0000 + i);
    upd();
    start = 1'b1; tran_cnt = 16'd4; dst_ready = 1'b0;
    step();
    start = 1'b0;
    step();
    #1;
    check_val("t6_pre_valid", dst_valid, 1);
    reset_n = 1'b0;
    #1;
    check_val("t6_rst_valid", dst_valid, 0);
    check_val("t6_rst_data", dst_data, 0);
    check_val("t6_rst_busy", busy, 0);
    check_val("t6_rst_remain", remain_cnt, 0);
    check_val("t6_rst_rd", fifo_rd, 0);
    step();
    reset_n = 1'b1;
    step(); step();
    check_val("t6_pops", n_pop, 1);
    check_val("t6_no_done", n_done, 0);
    check_val("t6_no_abort", n_abt, 0);
    clr();
    q.push_back(32'hF100_0000); q.push_back(32'hF100_0001); upd();
    start = 1'b1; tran_cnt = 16'd2; dst_ready = 1'b1;
    step();
    start = 1'b0;
    run_to_done(20);
    check_words("t6", 32'hF100_0000, 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
